wb_burst_master: RTL

Synthesizable Wishbone initiator that drives the Wishbone slave port of the SDRAM controller (sdrc_top). It accepts one transfer command at a time and issues a single-beat or incrementing-burst Wishbone cycle. Write commands drive a deterministic data pattern; read commands check returned data against the same pattern and count mismatches. It serves as the on-chip traffic generator and self-checker for the SDRAM subsystem, and is the bus-side counterpart of the controller.

---
 rtl/sdrc_wb_pkg.sv | 13 +
 rtl/wb_beat_gen.sv | 63 ++++++
 rtl/wb_burst_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sdrc_wb_pkg.sv
// Shared Wishbone constants and FSM state type for the SDRAM traffic generator.
package sdrc_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam int         ERR_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/wb_beat_gen.sv
// Beat sequencer: tracks the current beat index, its byte address and its
// pattern word, and flags the final beat of the burst.
module wb_beat_gen #(
  parameter int APP_AW = 26,
  parameter int DW     = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [APP_AW-1:0] start_addr,
  input  logic [DW-1:0]     seed,
  input  logic [LEN_W-1:0]  len,
  output logic [APP_AW-1:0] beat_addr,
  output logic [DW-1:0]     beat_data,
  output logic              last_beat,
  output logic              single_beat
);
  localparam logic [APP_AW-1:0] STEP = APP_AW'(DW / 8);

  logic [APP_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    idx_d  = idx_q;
    len_d  = len_q;
    if (load) begin
      addr_d = start_addr;
      data_d = seed;
      idx_d  = '0;
      len_d  = len;
    end else if (advance) begin
      // Address and pattern both wrap naturally at their own widths.
      addr_d = addr_q + STEP;
      data_d = data_q + DW'(1);
      idx_d  = idx_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
    end
  end

  assign beat_addr   = addr_q;
  assign beat_data   = data_q;
  assign last_beat   = (idx_q == len_q - LEN_W'(1));
  assign single_beat = (len_q == LEN_W'(1));
endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: writes a seed+k pattern or reads it back and
// counts mismatches, with a per-beat ack timeout.
module wb_burst_master
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int LEN_W  = 8,
  parameter int TMO_W  = 10
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_resetn,
  input  logic                 sdr_init_done,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [APP_AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [dw-1:0]        cmd_seed,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [APP_AW-1:0]    wb_addr_o,
  output logic [dw-1:0]        wb_dat_o,
  output logic [dw/8-1:0]      wb_sel_o,
  output logic [2:0]           wb_cti_o,
  input  logic                 wb_ack_i,
  input  logic [dw-1:0]        wb_dat_i,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [APP_AW-1:0]    first_err_addr,
  output logic                 timeout_err
);
  // Firing on this count value means 2^TMO_W-1 consecutive idle cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [APP_AW-1:0]     ferr_q, ferr_d;
  logic                  tmo_err_q, tmo_err_d;

  logic                  in_bus, accept, beat_ack, mismatch;
  logic [APP_AW-1:0]     beat_addr;
  logic [dw-1:0]         beat_data;
  logic                  last_beat, single_beat;

  assign in_bus    = (state_q == BUS);
  assign cmd_ready = wb_resetn && (state_q == IDLE) && sdr_init_done;
  assign accept    = cmd_valid && cmd_ready;
  assign beat_ack  = in_bus && wb_ack_i;
  assign mismatch  = beat_ack && !we_q && (wb_dat_i != beat_data);

  wb_beat_gen #(.APP_AW(APP_AW), .DW(dw), .LEN_W(LEN_W)) u_beat_gen (
    .clk         (wb_clk_i),
    .rst_n       (wb_resetn),
    .load        (accept),
    .advance     (beat_ack),
    .start_addr  (cmd_addr),
    .seed        (cmd_seed),
    .len         (cmd_len),
    .beat_addr   (beat_addr),
    .beat_data   (beat_data),
    .last_beat   (last_beat),
    .single_beat (single_beat)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d      = cmd_we;
          tmo_d     = '0;
          err_d     = '0;
          ferr_d    = '0;
          tmo_err_d = 1'b0;
          state_d   = (cmd_len == '0) ? DONE : BUS;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          tmo_d = '0;
          if (mismatch) begin
            if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + ERR_CNT_W'(1);
            // Count is cleared on accept and never wraps, so zero means "first".
            if (err_q == '0) ferr_d = beat_addr;
          end
          if (last_beat) state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      tmo_q     <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_we_o   = in_bus && we_q;
  assign wb_addr_o = in_bus ? beat_addr : '0;
  assign wb_dat_o  = in_bus ? beat_data : '0;
  assign wb_sel_o  = {(dw/8){in_bus}};
  assign wb_cti_o  = !in_bus     ? CTI_CLASSIC :
                     single_beat ? CTI_CLASSIC :
                     last_beat   ? CTI_EOB     : CTI_INCR;

  assign busy           = in_bus;
  assign done           = (state_q == DONE);
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
  assign timeout_err    = tmo_err_q;
endmodule
